// File: rtl/adc3wire_pkg.sv
// Shared definitions for the KAT ADC 3-wire configuration interface.
// Holds the responder FSM state encoding and the frame field positions.
// The configuration master builds its frames from the same constants.
`timescale 1ns/1ps
package adc3wire_pkg;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  localparam int FRAME_BITS = 32;
  localparam int HEADER_MSB = 31;
  localparam int HEADER_LSB = 20;
  localparam int ADDR_MSB   = 19;
  localparam int ADDR_LSB   = 16;
  localparam int DATA_MSB   = 15;
  localparam int DATA_LSB   = 0;

  // The bit counter stops one past a full frame, so long frames stay distinguishable.
  localparam logic [5:0] BIT_CNT_MAX = 6'(FRAME_BITS + 1);

endpackage

// File: rtl/adc3wire_sync.sv
// Multi-stage synchroniser for one asynchronous serial input.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset, clears every stage to 0
//   d    - asynchronous input
//   q    - synchronised output, SYNC_STAGES cycles of latency
`timescale 1ns/1ps
module adc3wire_sync
  import adc3wire_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/adc3wire_responder.sv
// ADC-side responder of the 3-wire configuration interface.
// Decodes 32-bit write frames {header[11:0], addr[3:0], data[15:0]} into a
// 16 x 16-bit register file, flags each committed write and each rejected
// frame with one-cycle pulses, and provides registered readback.
// Ports:
//   wb_clk_i, wb_rst_i         - system clock, asynchronous active-high reset
//   adc3wire_clk/data/strobe   - serial interface from the configuration master
//   rd_addr / rd_data          - register readback, one cycle of latency
//   wr_valid/wr_addr/wr_data   - committed-write pulse and its address/data
//   frame_err / err_cnt        - rejected-frame pulse and saturating counter
//   err_clr                    - synchronous clear of err_cnt (wins over an increment)
//   busy                       - high while a frame is being shifted in
`timescale 1ns/1ps
module adc3wire_responder
  import adc3wire_pkg::*;
#(
  parameter bit          STROBE_ACTIVE_LOW = 1'b1,
  parameter logic [11:0] HEADER            = 12'h001,
  parameter int          SYNC_STAGES       = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        adc3wire_clk,
  input  logic        adc3wire_data,
  input  logic        adc3wire_strobe,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        wr_valid,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  input  logic        err_clr,
  output logic        busy
);

  logic sclk_s, sdata_s, sstb_s;
  logic sclk_rise, strobe_act, frame_ok, commit_err;

  state_e      state_q, state_d;
  logic        sclk_prev_q, sclk_prev_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [15:0] regs_q [16];
  logic [15:0] regs_d [16];
  logic [15:0] rd_data_q, rd_data_d;
  logic        wr_valid_q, wr_valid_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Equal-depth synchronisers keep clk, data and strobe mutually aligned.
  adc3wire_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(adc3wire_clk), .q(sclk_s));
  adc3wire_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(adc3wire_data), .q(sdata_s));
  adc3wire_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stb (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(adc3wire_strobe), .q(sstb_s));

  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign strobe_act = STROBE_ACTIVE_LOW ? ~sstb_s : sstb_s;
  assign frame_ok   = (bit_cnt_q == 6'(FRAME_BITS)) &&
                      (shift_q[HEADER_MSB:HEADER_LSB] == HEADER);

  always_comb begin
    state_d     = state_q;
    sclk_prev_d = sclk_s;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    regs_d      = regs_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    commit_err  = 1'b0;

    case (state_q)
      // Out of reset the strobe may already be mid-frame; wait for it to go idle.
      ST_ARM: begin
        if (!strobe_act) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (strobe_act) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      // A clock edge coinciding with strobe release is not part of the frame.
      ST_SHIFT: begin
        if (!strobe_act) begin
          state_d = ST_CHECK;
        end else if (sclk_rise) begin
          shift_d = {shift_q[30:0], sdata_s};
          if (bit_cnt_q != BIT_CNT_MAX) bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (frame_ok) begin
          regs_d[shift_q[ADDR_MSB:ADDR_LSB]] = shift_q[DATA_MSB:DATA_LSB];
          wr_valid_d = 1'b1;
          wr_addr_d  = shift_q[ADDR_MSB:ADDR_LSB];
          wr_data_d  = shift_q[DATA_MSB:DATA_LSB];
        end else begin
          frame_err_d = 1'b1;
          commit_err  = 1'b1;
        end
      end
      default: state_d = ST_ARM;
    endcase

    if (err_clr) begin
      err_cnt_d = commit_err ? 8'd1 : 8'd0;
    end else if (commit_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end

    // Reads the pre-write contents, so a same-cycle write shows up one cycle later.
    rd_data_d = regs_q[rd_addr];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_ARM;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      rd_data_q   <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      regs_q      <= regs_d;
      rd_data_q   <= rd_data_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_adc3wire_responder.sv
// Bench for adc3wire_responder: one instance with an active-low strobe and one
// with an active-high strobe, driven by a behavioural 3-wire master.
`timescale 1ns/1ps
module tb_adc3wire_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_clk = 1'b0, a_data = 1'b0, a_stb = 1'b1, a_err_clr = 1'b0;
  logic [3:0]  a_rd_addr = '0;
  logic [15:0] a_rd_data, a_wr_data;
  logic [3:0]  a_wr_addr;
  logic        a_wr_valid, a_frame_err, a_busy;
  logic [7:0]  a_err_cnt;

  logic        b_clk = 1'b0, b_data = 1'b0, b_stb = 1'b0, b_err_clr = 1'b0;
  logic [3:0]  b_rd_addr = '0;
  logic [15:0] b_rd_data, b_wr_data;
  logic [3:0]  b_wr_addr;
  logic        b_wr_valid, b_frame_err, b_busy;
  logic [7:0]  b_err_cnt;

  adc3wire_responder dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .adc3wire_clk(a_clk), .adc3wire_data(a_data), .adc3wire_strobe(a_stb),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .wr_valid(a_wr_valid), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .frame_err(a_frame_err), .err_cnt(a_err_cnt), .err_clr(a_err_clr),
    .busy(a_busy));

  adc3wire_responder #(.STROBE_ACTIVE_LOW(1'b0)) dut_hi (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .adc3wire_clk(b_clk), .adc3wire_data(b_data), .adc3wire_strobe(b_stb),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .wr_valid(b_wr_valid), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .frame_err(b_frame_err), .err_cnt(b_err_cnt), .err_clr(b_err_clr),
    .busy(b_busy));

  int pass_cnt  = 0;
  int total_cnt = 0;
  int a_wr_pulses = 0, a_err_pulses = 0, b_wr_pulses = 0, b_err_pulses = 0;
  logic both_seen = 1'b0;

  always @(posedge clk) begin
    if (a_wr_valid)  a_wr_pulses++;
    if (a_frame_err) a_err_pulses++;
    if (b_wr_valid)  b_wr_pulses++;
    if (b_frame_err) b_err_pulses++;
    if ((a_wr_valid && a_frame_err) || (b_wr_valid && b_frame_err)) both_seen = 1'b1;
  end

  // Reference model: register contents and error count per instance.
  logic [15:0] model_regs [2][16];
  int          model_err [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      model_err[i] = 0;
      for (int j = 0; j < 16; j++) model_regs[i][j] = '0;
    end
  endtask

  task automatic set_clk(input bit inst, input logic v);
    if (inst) b_clk = v; else a_clk = v;
  endtask
  task automatic set_data(input bit inst, input logic v);
    if (inst) b_data = v; else a_data = v;
  endtask
  task automatic set_stb(input bit inst, input logic act);
    if (inst) b_stb = act; else a_stb = ~act;
  endtask

  task automatic read_chk(input bit inst, input logic [3:0] addr, input string tag);
    @(negedge clk);
    if (inst) b_rd_addr = addr; else a_rd_addr = addr;
    @(posedge clk);
    #1;
    check(tag, inst ? b_rd_data : a_rd_data, model_regs[inst][addr]);
  endtask

  // Sends the low nbits of vec MSB first with an 8-cycle half-period.
  // rst_at >= 0 pulses reset after that many bits; clr pulses err_clr in the check cycle.
  task automatic do_frame(input bit inst, input logic [63:0] vec, input int nbits,
                          input int rst_at, input bit clr, input string tag);
    int wr0, err0;
    logic ok, bad, seen;
    logic [3:0] adr;
    logic [15:0] old;
    ok  = (nbits == 32) && (vec[31:20] == 12'h001) && (rst_at < 0);
    bad = !ok && (rst_at < 0);
    adr = vec[19:16];
    if (inst) b_rd_addr = adr; else a_rd_addr = adr;
    wr0  = inst ? b_wr_pulses  : a_wr_pulses;
    err0 = inst ? b_err_pulses : a_err_pulses;
    set_stb(inst, 1'b1);
    cycles(8);
    for (int i = nbits - 1; i >= 0; i--) begin
      set_data(inst, vec[i]);
      set_clk(inst, 1'b0);
      cycles(8);
      set_clk(inst, 1'b1);
      cycles(8);
      if (nbits - i == rst_at) begin
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        model_reset();
        wr0 = 0; err0 = 0;
        wr0  = inst ? b_wr_pulses  : a_wr_pulses;
        err0 = inst ? b_err_pulses : a_err_pulses;
      end
    end
    set_clk(inst, 1'b0);
    cycles(8);
    set_stb(inst, 1'b0);
    old  = model_regs[inst][adr];
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cycles(1);
      if (!(inst ? b_busy : a_busy)) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_busy_drop"}, seen, 1'b1);
    if (clr) begin
      if (inst) b_err_clr = 1'b1; else a_err_clr = 1'b1;
    end
    cycles(1);
    a_err_clr = 1'b0;
    b_err_clr = 1'b0;
    check({tag, "_wr_valid"},  inst ? b_wr_valid  : a_wr_valid,  ok);
    check({tag, "_frame_err"}, inst ? b_frame_err : a_frame_err, bad);
    check({tag, "_rd_old"},    inst ? b_rd_data   : a_rd_data,   old);
    if (ok) model_regs[inst][adr] = vec[15:0];
    if (bad) model_err[inst] = clr ? 1 : ((model_err[inst] < 255) ? model_err[inst] + 1 : 255);
    cycles(1);
    check({tag, "_rd_new"}, inst ? b_rd_data : a_rd_data, model_regs[inst][adr]);
    cycles(6);
    check({tag, "_wr_pulses"},  (inst ? b_wr_pulses  : a_wr_pulses)  - wr0,  ok);
    check({tag, "_err_pulses"}, (inst ? b_err_pulses : a_err_pulses) - err0, bad);
    check({tag, "_err_cnt"}, inst ? b_err_cnt : a_err_cnt, model_err[inst]);
    if (ok) begin
      check({tag, "_wr_addr"}, inst ? b_wr_addr : a_wr_addr, adr);
      check({tag, "_wr_data"}, inst ? b_wr_data : a_wr_data, vec[15:0]);
    end
  endtask

  initial begin
    logic [63:0] vec;
    logic [11:0] hdr;
    logic [15:0] k16;
    int nb;

    model_reset();
    cycles(3);
    check("rst_rd_data",   a_rd_data,   16'h0);
    check("rst_wr_valid",  a_wr_valid,  1'b0);
    check("rst_frame_err", a_frame_err, 1'b0);
    check("rst_busy",      a_busy,      1'b0);
    rst = 1'b0;
    cycles(4);
    check("rel_err_cnt", a_err_cnt, 8'h0);
    check("rel_wr_addr", a_wr_addr, 4'h0);
    check("rel_wr_data", a_wr_data, 16'h0);
    check("rel_busy",    a_busy,    1'b0);
    read_chk(0, 4'd9, "rst_reg9");

    // Single write frame
    do_frame(0, 64'h0015A5C3, 32, -1, 1'b0, "write");
    read_chk(0, 4'd5, "write_rb5");

    // Full register map
    for (int k = 0; k < 16; k++) begin
      k16 = 16'(k);
      do_frame(0, {32'h0, 12'h001, k16[3:0], 16'h1111 * k16}, 32, -1, 1'b0, "map");
    end
    for (int k = 0; k < 16; k++) read_chk(0, 4'(k), "map_rb");

    // Short frame
    do_frame(0, 64'h0015A5C3, 31, -1, 1'b0, "short");
    read_chk(0, 4'd5, "short_rb5");

    // Bad header, long frame, then clear colliding with an error
    a_err_clr = 1'b1;
    cycles(1);
    a_err_clr = 1'b0;
    model_err[0] = 0;
    check("clr_alone", a_err_cnt, 8'h0);
    do_frame(0, 64'h0025FFFF, 32, -1, 1'b0, "badhdr");
    do_frame(0, 64'h0_0015A5C3, 33, -1, 1'b0, "long");
    do_frame(0, 64'h0035BEEF, 32, -1, 1'b1, "clr_err");
    read_chk(0, 4'd5, "err_rb5");

    // Randomised frames
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 5))
        0: nb = 31;
        1: nb = 33;
        default: nb = 32;
      endcase
      vec = {$urandom, $urandom};
      hdr = 12'h001;
      if ($urandom_range(0, 3) == 0) begin
        hdr = 12'($urandom);
        if (hdr == 12'h001) hdr = 12'h800;
      end
      if (nb != 33) vec[63:32] = '0;
      if (nb == 32) vec[31:20] = hdr;
      do_frame(0, vec, nb, -1, 1'b0, "rand");
    end
    for (int k = 0; k < 16; k++) read_chk(0, 4'(k), "rand_rb");

    // Reset in the middle of a frame, then a clean frame
    do_frame(0, 64'h001A1234, 32, 12, 1'b0, "rstmid");
    read_chk(0, 4'd10, "rstmid_rb10");
    do_frame(0, 64'h00130042, 32, -1, 1'b0, "after_rst");
    read_chk(0, 4'd3, "after_rst_rb3");

    // Active-high strobe instance
    do_frame(1, 64'h001F8001, 32, -1, 1'b0, "pol");
    read_chk(1, 4'd15, "pol_rb15");

    check("never_both", both_seen, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/adc3wire_responder.md
Name: adc3wire_responder

Overview:
Responder (ADC-side end) of the KAT ADC 3-wire serial configuration interface. It decodes 32-bit write frames from the configuration master into a 16 x 16-bit register file, exposes each committed write as a one-cycle strobe, and offers registered readback plus error counters. It is used as an ADC configuration-port model in on-FPGA loopback and emulation builds, clocked from the same wishbone clock domain as the master.

Parameters:
STROBE_ACTIVE_LOW, 1, when 1 a frame is active while adc3wire_strobe=0; when 0, while adc3wire_strobe=1
HEADER, 12'h001, required value of frame bits [31:20]
SYNC_STAGES, 2, flop stages on each serial input (minimum 2)

Ports:
wb_clk_i  in  1  system clock; all logic is on its rising edge
wb_rst_i  in  1  asynchronous, active-high reset
adc3wire_clk  in  1  serial clock; data is sampled on its rising edge
adc3wire_data  in  1  serial data, MSB first
adc3wire_strobe  in  1  frame enable; polarity set by STROBE_ACTIVE_LOW
rd_addr  in  4  readback address
rd_data  out  16  register file readback, 1-cycle latency
wr_valid  out  1  one-cycle pulse per committed write
wr_addr  out  4  address of the last committed write
wr_data  out  16  data of the last committed write
frame_err  out  1  one-cycle pulse per rejected frame
err_cnt  out  8  rejected-frame count; saturates at 255
err_clr  in  1  synchronous clear of err_cnt
busy  out  1  high while a frame is in progress (SHIFT state)

Behaviour:
- Reset values: all outputs are 0, all 16 registers are 0, and the FSM is in ARM.
- Synchronisation: clk, data and strobe each pass through SYNC_STAGES flops with identical depth, so they stay mutually aligned. sclk_rise is the synced clk with previous=0 and current=1. strobe_act is the synced strobe after polarity correction.
- FSM states: ARM, IDLE, SHIFT, CHECK.
  - ARM: go to IDLE once strobe_act=0. This prevents a partial frame being decoded when reset releases mid-frame.
  - IDLE: go to SHIFT when strobe_act=1. On entry to SHIFT, clear bit_cnt (6 bits) and shift (32 bits).
  - SHIFT: on each sclk_rise with strobe_act=1, shift in the data bit (shift <= {shift[30:0], d}) and increment bit_cnt, saturating at 33. When strobe_act=0, go to CHECK. If sclk_rise and strobe deassertion fall in the same cycle, the bit is discarded.
  - CHECK (exactly one cycle, then IDLE):
    - Valid frame (bit_cnt==32 and shift[31:20]==HEADER): reg[shift[19:16]] <= shift[15:0]; wr_addr/wr_data are updated; wr_valid=1 for that one cycle.
    - Any other case (short frame, long frame, or header mismatch): no write; frame_err=1 for one cycle; err_cnt increments.
- Outputs wr_valid and frame_err are registered and asserted during the cycle after CHECK. They never assert together.
- Readback: rd_data <= reg[rd_addr] every cycle. When the write and the read target the same address in the same cycle, the old value is returned; the new value appears one cycle later.
- err_cnt: err_clr has priority. If err_clr and an error occur in the same cycle, err_cnt becomes 1.
- busy = (state==SHIFT).
- Timing: the input must hold each clk level for at least SYNC_STAGES+1 clock cycles. The master's 8-cycle half-period satisfies this.
- Asynchronous reset at any point aborts the frame; no write occurs.

Decomposition:
- Shared package adc3wire_pkg: FSM state encoding (ARM/IDLE/SHIFT/CHECK), FRAME_BITS=32, HEADER_MSB/LSB=31/20, ADDR_MSB/LSB=19/16, DATA_MSB/LSB=15/0. The master uses the same field constants when it builds frames.
- Sub-module adc3wire_sync: a parameterised SYNC_STAGES synchroniser with async reset, instantiated three times.

Test Plan:
- Write frame: master sends 0x0015A5C3 with an 8-cycle half-period, active-low strobe -> wr_valid pulses once, wr_addr=5, wr_data=0xA5C3; rd_addr=5 gives rd_data=0xA5C3 one cycle later; err_cnt=0.
- Full map: 16 frames write address k with data 0x1111*k -> each rd_addr=k reads back 0x1111*k, with no errors.
- Short frame: strobe deasserts after 31 bits -> no write, frame_err pulses, err_cnt=1, and reg contents are unchanged.
- Bad header and long frame: frame 0x0025FFFF, then a 33-bit frame -> both rejected, err_cnt=2. err_clr together with a third error gives err_cnt=1.
- Reset mid-frame: assert wb_rst_i at bit 12 and release it with strobe still active -> FSM stays in ARM, the remaining bits are ignored with no write or error; the next valid frame 0x00130042 writes reg[3]=0x0042.
- Polarity: with STROBE_ACTIVE_LOW=0 and an active-high strobe, frame 0x001F8001 -> reg[15]=0x8001.
